// File: rtl/hilo_muldiv_if.sv
// Operand, start and result signals between the control unit and the HI/LO
// multiply/divide unit.
interface hilo_muldiv_if;
   logic [31:0] A;
   logic [31:0] B;
   logic        MultCtrl;
   logic        DivCtrl;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        Busy;
   logic        MultDone;
   logic        DivDone;
   logic        DivZero;

   modport master (
      output A, B, MultCtrl, DivCtrl,
      input  HI, LO, Busy, MultDone, DivDone, DivZero
   );

   modport slave (
      input  A, B, MultCtrl, DivCtrl,
      output HI, LO, Busy, MultDone, DivDone, DivZero
   );
endinterface

// File: rtl/hilo_muldiv.sv
// Sequential signed 32x32 multiply / 32/32 divide producing HI and LO.
// A start in IDLE costs 34 cycles to Done; divide by zero is flagged immediately.
module hilo_muldiv (
   input  logic          clk,
   input  logic          reset,
   hilo_muldiv_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StMult, StDiv, StFinish} state_e;

   state_e      state_q;
   logic [4:0]  count_q;
   logic [63:0] mcand_q;
   logic [31:0] mplier_q;
   logic [63:0] prod_q;
   logic [31:0] divisor_q;
   logic [31:0] quot_q;
   logic [31:0] rem_q;
   logic        is_div_q;
   logic        neg_res_q;
   logic        neg_rem_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        busy_q;
   logic        mult_done_q;
   logic        div_done_q;
   logic        div_zero_q;

   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] rem_shift;
   logic [32:0] rem_diff;

   // Magnitudes wrap modulo 2^32, so 0x80000000 stays 2^31 as an unsigned value.
   always_comb begin
      abs_a     = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
      abs_b     = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
      rem_shift = {rem_q, quot_q[31]};
      rem_diff  = rem_shift - {1'b0, divisor_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         count_q     <= 5'd0;
         mcand_q     <= 64'd0;
         mplier_q    <= 32'd0;
         prod_q      <= 64'd0;
         divisor_q   <= 32'd0;
         quot_q      <= 32'd0;
         rem_q       <= 32'd0;
         is_div_q    <= 1'b0;
         neg_res_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
         busy_q      <= 1'b0;
         mult_done_q <= 1'b0;
         div_done_q  <= 1'b0;
         div_zero_q  <= 1'b0;
      end else begin
         mult_done_q <= 1'b0;
         div_done_q  <= 1'b0;
         div_zero_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.MultCtrl) begin
                  mcand_q   <= {32'd0, abs_a};
                  mplier_q  <= abs_b;
                  prod_q    <= 64'd0;
                  neg_res_q <= bus.A[31] ^ bus.B[31];
                  is_div_q  <= 1'b0;
                  count_q   <= 5'd0;
                  busy_q    <= 1'b1;
                  state_q   <= StMult;
               end else if (bus.DivCtrl) begin
                  if (bus.B != 32'd0) begin
                     divisor_q <= abs_b;
                     quot_q    <= abs_a;
                     rem_q     <= 32'd0;
                     neg_res_q <= bus.A[31] ^ bus.B[31];
                     neg_rem_q <= bus.A[31];
                     is_div_q  <= 1'b1;
                     count_q   <= 5'd0;
                     busy_q    <= 1'b1;
                     state_q   <= StDiv;
                  end else begin
                     div_zero_q <= 1'b1;
                  end
               end
            end
            StMult: begin
               if (mplier_q[0]) begin
                  prod_q <= prod_q + mcand_q;
               end
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + 5'd1;
               if (count_q == 5'd31) begin
                  state_q <= StFinish;
               end
            end
            StDiv: begin
               // Dividend bits shift out of quot_q as quotient bits shift in.
               if (!rem_diff[32]) begin
                  rem_q  <= rem_diff[31:0];
                  quot_q <= {quot_q[30:0], 1'b1};
               end else begin
                  rem_q  <= rem_shift[31:0];
                  quot_q <= {quot_q[30:0], 1'b0};
               end
               count_q <= count_q + 5'd1;
               if (count_q == 5'd31) begin
                  state_q <= StFinish;
               end
            end
            StFinish: begin
               if (is_div_q) begin
                  lo_q       <= neg_res_q ? (~quot_q + 32'd1) : quot_q;
                  hi_q       <= neg_rem_q ? (~rem_q + 32'd1) : rem_q;
                  div_done_q <= 1'b1;
               end else begin
                  {hi_q, lo_q} <= neg_res_q ? (~prod_q + 64'd1) : prod_q;
                  mult_done_q  <= 1'b1;
               end
               busy_q  <= 1'b0;
               count_q <= 5'd0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.HI       = hi_q;
   assign bus.LO       = lo_q;
   assign bus.Busy     = busy_q;
   assign bus.MultDone = mult_done_q;
   assign bus.DivDone  = div_done_q;
   assign bus.DivZero  = div_zero_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized self-checking bench for hilo_muldiv against a signed 64-bit
// arithmetic reference model.
module tb_hilo_muldiv;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass = 0;

   hilo_muldiv_if bus ();

   hilo_muldiv dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: full-precision signed arithmetic, C-style truncating division.
   function automatic logic [63:0] model(input bit is_div, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!is_div) return sa * sb;
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic run_op(input string tag, input bit do_mult, input bit do_div,
                         input logic [31:0] a, input logic [31:0] b, input bit interfere);
      logic [63:0] exp;
      logic [31:0] prev_hi, prev_lo;
      bit          exp_div;
      int          busy_err = 0, hold_err = 0, n_right = 0, n_wrong = 0, done_cyc = 0;
      exp_div = !do_mult;
      exp     = model(exp_div, a, b);
      prev_hi = bus.HI;
      prev_lo = bus.LO;
      bus.A = a;
      bus.B = b;
      bus.MultCtrl = do_mult;
      bus.DivCtrl  = do_div;
      tick();
      bus.MultCtrl = 1'b0;
      bus.DivCtrl  = 1'b0;
      for (int cyc = 1; cyc <= 34; cyc++) begin
         if (bus.Busy !== (cyc <= 33)) busy_err++;
         if (cyc <= 33 && (bus.HI !== prev_hi || bus.LO !== prev_lo)) hold_err++;
         if ((exp_div ? bus.DivDone : bus.MultDone) === 1'b1) begin
            n_right++;
            done_cyc = cyc;
         end
         if ((exp_div ? bus.MultDone : bus.DivDone) !== 1'b0 || bus.DivZero !== 1'b0) n_wrong++;
         if (cyc < 34) begin
            // Operands and start pulses after cycle 0 must have no effect.
            bus.A = $urandom;
            bus.B = $urandom;
            bus.MultCtrl = interfere && (cyc == 5);
            bus.DivCtrl  = interfere && (cyc == 20);
            tick();
            bus.MultCtrl = 1'b0;
            bus.DivCtrl  = 1'b0;
         end
      end
      check({tag, "/hi"}, bus.HI, exp[63:32]);
      check({tag, "/lo"}, bus.LO, exp[31:0]);
      check({tag, "/busy_seq_errs"}, busy_err, 0);
      check({tag, "/hold_errs"}, hold_err, 0);
      check({tag, "/done_count"}, n_right, 1);
      check({tag, "/done_cycle"}, done_cyc, 34);
      check({tag, "/stray_flags"}, n_wrong, 0);
   endtask

   initial begin
      int n_md;
      logic [31:0] edge_vals [5];
      logic [31:0] ra, rb;
      bit          rm;
      edge_vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

      bus.A = 32'd0;
      bus.B = 32'd0;
      bus.MultCtrl = 1'b0;
      bus.DivCtrl  = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      check("rst/hi", bus.HI, 0);
      check("rst/lo", bus.LO, 0);
      check("rst/flags", {bus.Busy, bus.MultDone, bus.DivDone, bus.DivZero}, 0);
      reset = 1'b0;
      tick();

      run_op("mul_7x-3", 1, 0, 32'd7, 32'hFFFF_FFFD, 0);
      run_op("mul_min2", 1, 0, 32'h8000_0000, 32'h8000_0000, 0);
      run_op("mul_2p32", 1, 0, 32'h0001_0000, 32'h0001_0000, 0);
      run_op("div_-7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("div_min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("div_setup", 0, 1, 32'h0000_2211, 32'h0000_0100, 0);

      // Divide by zero: immediate flag, HI/LO untouched, new start accepted next cycle.
      bus.A = 32'd1234;
      bus.B = 32'd0;
      bus.DivCtrl = 1'b1;
      tick();
      bus.DivCtrl = 1'b0;
      check("dz/flag", bus.DivZero, 1);
      check("dz/busy", bus.Busy, 0);
      check("dz/done", {bus.DivDone, bus.MultDone}, 0);
      check("dz/hi", bus.HI, 32'h11);
      check("dz/lo", bus.LO, 32'h22);
      run_op("after_dz", 1, 0, 32'hFFFF_F000, 32'd3, 0);

      // Reset in cycle 10 of a MULT, with a simultaneous start that must be dropped.
      bus.A = 32'd5;
      bus.B = 32'd6;
      bus.MultCtrl = 1'b1;
      tick();
      bus.MultCtrl = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      reset = 1'b1;
      bus.MultCtrl = 1'b1;
      tick();
      reset = 1'b0;
      bus.MultCtrl = 1'b0;
      check("rmid/hi", bus.HI, 0);
      check("rmid/lo", bus.LO, 0);
      check("rmid/busy", bus.Busy, 0);
      n_md = 0;
      for (int cyc = 11; cyc <= 40; cyc++) begin
         if (bus.MultDone !== 1'b0 || bus.Busy !== 1'b0) n_md++;
         tick();
      end
      check("rmid/quiet", n_md, 0);

      run_op("div_interf", 0, 1, 32'hFFFF_FF00, 32'd7, 1);
      run_op("both_start", 1, 1, 32'h0000_1234, 32'hFFFF_0001, 0);

      for (int i = 0; i < 20; i++) begin
         rm = 1'($urandom_range(0, 1));
         ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
         if (!rm && rb == 32'd0) rb = 32'd3;
         run_op(rm ? "rnd_mul" : "rnd_div", rm, !rm, ra, rb, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
